// File: rtl/parking_gate_ctrl_if.sv
// rtl/parking_gate_ctrl_if.sv - sensor, vacancy and event signals between gate front end and Parking core
interface parking_gate_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             entry_req;
    logic             entry_is_uni;
    logic             exit_req;
    logic             exit_is_uni;
    logic             uni_is_vacated_space;
    logic             is_vacated_space;
    logic             car_entered;
    logic             is_uni_car_entered;
    logic             car_exited;
    logic             is_uni_car_exited;
    logic             entry_barrier_open;
    logic             exit_barrier_open;
    logic             entry_denied;
    logic [CNT_W-1:0] grant_count;
    logic [CNT_W-1:0] deny_count;

    // gate controller side
    modport slave (
        input  entry_req, entry_is_uni, exit_req, exit_is_uni,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output entry_barrier_open, exit_barrier_open, entry_denied,
        output grant_count, deny_count
    );

    // sensor / Parking core side
    modport master (
        output entry_req, entry_is_uni, exit_req, exit_is_uni,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  entry_barrier_open, exit_barrier_open, entry_denied,
        input  grant_count, deny_count
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - entry/exit lane qualification, vacancy decision, event pulses and barriers
module parking_gate_ctrl #(
    parameter int SENSOR_STABLE  = 3,
    parameter int BARRIER_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input logic                CLK,
    input logic                Start,
    parking_gate_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, QUAL, DECIDE, OPEN, CLEAR} lane_state_e;

    localparam logic [3:0]       STABLE_C = 4'(SENSOR_STABLE);
    localparam logic [7:0]       BAR_C    = 8'(BARRIER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    lane_state_e      en_state_q, en_state_d, ex_state_q, ex_state_d;
    logic [3:0]       en_qcnt_q, en_qcnt_d, ex_qcnt_q, ex_qcnt_d;
    logic [7:0]       en_ocnt_q, en_ocnt_d, ex_ocnt_q, ex_ocnt_d;
    logic             en_cls_q, en_cls_d, ex_cls_q, ex_cls_d;
    logic             car_entered_q, car_entered_d, uni_entered_q, uni_entered_d;
    logic             car_exited_q, car_exited_d, uni_exited_q, uni_exited_d;
    logic             en_bar_q, en_bar_d, ex_bar_q, ex_bar_d;
    logic             denied_q, denied_d;
    logic [CNT_W-1:0] grant_q, grant_d, deny_q, deny_d;
    logic             en_vacant;

    // state and registered outputs; reset drops every lane to IDLE with no pending event
    always_ff @(posedge CLK) begin
        if (Start) begin
            en_state_q    <= IDLE;
            ex_state_q    <= IDLE;
            en_qcnt_q     <= '0;
            ex_qcnt_q     <= '0;
            en_ocnt_q     <= '0;
            ex_ocnt_q     <= '0;
            en_cls_q      <= 1'b0;
            ex_cls_q      <= 1'b0;
            car_entered_q <= 1'b0;
            uni_entered_q <= 1'b0;
            car_exited_q  <= 1'b0;
            uni_exited_q  <= 1'b0;
            en_bar_q      <= 1'b0;
            ex_bar_q      <= 1'b0;
            denied_q      <= 1'b0;
            grant_q       <= '0;
            deny_q        <= '0;
        end else begin
            en_state_q    <= en_state_d;
            ex_state_q    <= ex_state_d;
            en_qcnt_q     <= en_qcnt_d;
            ex_qcnt_q     <= ex_qcnt_d;
            en_ocnt_q     <= en_ocnt_d;
            ex_ocnt_q     <= ex_ocnt_d;
            en_cls_q      <= en_cls_d;
            ex_cls_q      <= ex_cls_d;
            car_entered_q <= car_entered_d;
            uni_entered_q <= uni_entered_d;
            car_exited_q  <= car_exited_d;
            uni_exited_q  <= uni_exited_d;
            en_bar_q      <= en_bar_d;
            ex_bar_q      <= ex_bar_d;
            denied_q      <= denied_d;
            grant_q       <= grant_d;
            deny_q        <= deny_d;
        end
    end

    // entry lane: qualify, check vacancy (yielding to a simultaneous exit decision), open, clear
    always_comb begin
        en_state_d    = en_state_q;
        en_qcnt_d     = en_qcnt_q;
        en_ocnt_d     = en_ocnt_q;
        en_cls_d      = en_cls_q;
        en_bar_d      = en_bar_q;
        car_entered_d = 1'b0;
        uni_entered_d = 1'b0;
        denied_d      = 1'b0;
        grant_d       = grant_q;
        deny_d        = deny_q;
        en_vacant     = en_cls_q ? bus.uni_is_vacated_space : bus.is_vacated_space;
        case (en_state_q)
            IDLE: begin
                if (bus.entry_req) begin
                    en_qcnt_d = 4'd1;
                    if (STABLE_C == 4'd1) begin
                        en_state_d = DECIDE;
                        en_cls_d   = bus.entry_is_uni;
                    end else begin
                        en_state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (!bus.entry_req) begin
                    en_state_d = IDLE;
                    en_qcnt_d  = '0;
                end else if (en_qcnt_q + 4'd1 == STABLE_C) begin
                    en_state_d = DECIDE;
                    en_qcnt_d  = en_qcnt_q + 4'd1;
                    en_cls_d   = bus.entry_is_uni;
                end else begin
                    en_qcnt_d = en_qcnt_q + 4'd1;
                end
            end
            DECIDE: begin
                // exit owns the event slot this cycle; re-evaluate vacancy next cycle
                if (ex_state_q != DECIDE) begin
                    en_qcnt_d = '0;
                    if (en_vacant) begin
                        car_entered_d = 1'b1;
                        uni_entered_d = en_cls_q;
                        grant_d       = grant_q + CNT_ONE;
                        en_bar_d      = 1'b1;
                        en_ocnt_d     = 8'd1;
                        en_state_d    = OPEN;
                    end else begin
                        denied_d   = 1'b1;
                        deny_d     = deny_q + CNT_ONE;
                        en_state_d = CLEAR;
                    end
                end
            end
            OPEN: begin
                if (en_ocnt_q == BAR_C) begin
                    en_bar_d   = 1'b0;
                    en_ocnt_d  = '0;
                    en_state_d = CLEAR;
                end else begin
                    en_ocnt_d = en_ocnt_q + 8'd1;
                end
            end
            CLEAR: begin
                if (!bus.entry_req) en_state_d = IDLE;
            end
            default: en_state_d = IDLE;
        endcase
    end

    // exit lane: same qualification, always granted, has priority on the event slot
    always_comb begin
        ex_state_d   = ex_state_q;
        ex_qcnt_d    = ex_qcnt_q;
        ex_ocnt_d    = ex_ocnt_q;
        ex_cls_d     = ex_cls_q;
        ex_bar_d     = ex_bar_q;
        car_exited_d = 1'b0;
        uni_exited_d = 1'b0;
        case (ex_state_q)
            IDLE: begin
                if (bus.exit_req) begin
                    ex_qcnt_d = 4'd1;
                    if (STABLE_C == 4'd1) begin
                        ex_state_d = DECIDE;
                        ex_cls_d   = bus.exit_is_uni;
                    end else begin
                        ex_state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (!bus.exit_req) begin
                    ex_state_d = IDLE;
                    ex_qcnt_d  = '0;
                end else if (ex_qcnt_q + 4'd1 == STABLE_C) begin
                    ex_state_d = DECIDE;
                    ex_qcnt_d  = ex_qcnt_q + 4'd1;
                    ex_cls_d   = bus.exit_is_uni;
                end else begin
                    ex_qcnt_d = ex_qcnt_q + 4'd1;
                end
            end
            DECIDE: begin
                ex_qcnt_d    = '0;
                car_exited_d = 1'b1;
                uni_exited_d = ex_cls_q;
                ex_bar_d     = 1'b1;
                ex_ocnt_d    = 8'd1;
                ex_state_d   = OPEN;
            end
            OPEN: begin
                if (ex_ocnt_q == BAR_C) begin
                    ex_bar_d   = 1'b0;
                    ex_ocnt_d  = '0;
                    ex_state_d = CLEAR;
                end else begin
                    ex_ocnt_d = ex_ocnt_q + 8'd1;
                end
            end
            CLEAR: begin
                if (!bus.exit_req) ex_state_d = IDLE;
            end
            default: ex_state_d = IDLE;
        endcase
    end

    assign bus.car_entered        = car_entered_q;
    assign bus.is_uni_car_entered = uni_entered_q;
    assign bus.car_exited         = car_exited_q;
    assign bus.is_uni_car_exited  = uni_exited_q;
    assign bus.entry_barrier_open = en_bar_q;
    assign bus.exit_barrier_open  = ex_bar_q;
    assign bus.entry_denied       = denied_q;
    assign bus.grant_count        = grant_q;
    assign bus.deny_count         = deny_q;
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate-side front end of the parking manager: qualifies raw entry/exit loop-sensor levels, checks vacancy flags returned by the `Parking` core, and issues clean one-cycle `car_entered`/`car_exited` event pulses with their class bits into that core. It also drives the two barrier outputs and counts granted and denied entries. It sits directly upstream of `Parking` and shares its clock and reset.

## Interface
- `SENSOR_STABLE`, 3: consecutive high samples required to qualify a sensor request (1..15).
- `BARRIER_CYCLES`, 8: cycles a barrier stays open after a grant (1..255).
- `CNT_W`, 16: width of the grant/deny counters.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `Start`  in  1  reset: synchronous, active-high.
- `entry_req`  in  1  entry loop sensor level (vehicle present).
- `entry_is_uni`  in  1  entry vehicle carries a university tag.
- `exit_req`  in  1  exit loop sensor level.
- `exit_is_uni`  in  1  exit vehicle carries a university tag.
- `uni_is_vacated_space`  in  1  from `Parking`: a university space is free.
- `is_vacated_space`  in  1  from `Parking`: a public space is free.
- `car_entered`  out  1  one-cycle entry event to `Parking`.
- `is_uni_car_entered`  out  1  class of the entry event; valid with `car_entered`, else 0.
- `car_exited`  out  1  one-cycle exit event to `Parking`.
- `is_uni_car_exited`  out  1  class of the exit event; valid with `car_exited`, else 0.
- `entry_barrier_open`  out  1  entry barrier command.
- `exit_barrier_open`  out  1  exit barrier command.
- `entry_denied`  out  1  one-cycle pulse: entry refused for lack of space.
- `grant_count`  out  `CNT_W`  granted entries since reset; wraps.
- `deny_count`  out  `CNT_W`  denied entries since reset; wraps.

## Operation
- There are two independent lane FSMs, entry and exit. States: IDLE → QUAL → DECIDE → OPEN → CLEAR → IDLE.
- **IDLE:**
  - Sensor sampled high: go to QUAL with the qualification counter set to 1.
  - If `SENSOR_STABLE` = 1, go straight to DECIDE.
- **QUAL:**
  - Each high sample increments the counter.
  - A low sample returns the lane to IDLE and clears the counter.
  - Reaching `SENSOR_STABLE` moves the lane to DECIDE.
  - The class bit is latched on the final qualifying sample.
- **Entry DECIDE:**
  - Vacancy check: a uni car needs `uni_is_vacated_space` = 1; a public car needs `is_vacated_space` = 1.
  - Grant: pulse `car_entered` with the latched class, increment `grant_count`, go to OPEN.
  - Deny: pulse `entry_denied`, increment `deny_count`, go to CLEAR. The barrier stays closed.
- **Exit DECIDE:** always grants. It pulses `car_exited` with the latched class, then goes to OPEN.
- **OPEN:** the barrier is held for exactly `BARRIER_CYCLES` cycles, then the lane goes to CLEAR.
- **CLEAR:** the lane waits for one low sample of its sensor, then returns to IDLE. A vehicle lingering on the loop is never counted twice.
- **Arbitration:** `Parking` accepts at most one event per cycle.
  - If both lanes are in DECIDE in the same cycle, exit wins.
  - Entry stays in DECIDE one more cycle and re-evaluates vacancy with the updated flags.
  - `car_entered` and `car_exited` are never high in the same cycle.
- **Counters:** `grant_count` and `deny_count` wrap from 2^`CNT_W`−1 to 0 with no flag.

## Timing
- All outputs are registered.
- Reset values:
  - All 1-bit outputs are 0.
  - Both counters are 0.
  - Both FSMs are in IDLE with their qualification counters at 0.
- Let edge 1 be the first edge sampling the sensor high:
  - With `SENSOR_STABLE` = S, the lane is in DECIDE after edge S.
  - The event pulse (or `entry_denied`) and the barrier rise on edge S+1, absent arbitration stall.
- An event pulse lasts exactly 1 cycle. The class output equals the latched class during the pulse and is 0 otherwise.
- The barrier is high for exactly `BARRIER_CYCLES` cycles, starting on the pulse edge.
- Vacancy flags are sampled on the decision edge only; later changes do not revoke a grant.
- An arbitration stall adds 1 cycle to entry latency per colliding cycle.
- The earliest re-trigger is the edge after the first low sample in CLEAR.
- Reset asserted mid-operation: on that edge every lane returns to IDLE and all outputs go to 0. No pending event is issued, and no partial pulse appears after reset releases.

## Test plan
- **Reset:** hold `Start` 2 cycles with both sensors high → all outputs 0 and both counts 0. After release, the first `car_entered` appears on edge 4.
- **Uni entry with space:** `entry_req`=1 and `entry_is_uni`=1 for 20 cycles, `uni_is_vacated_space`=1 → on edge 4, `car_entered`=`is_uni_car_entered`=1 for 1 cycle; `entry_barrier_open` is high for 8 cycles; `grant_count`=1; no second event until `entry_req` drops.
- **Public entry, lot full:** `is_vacated_space`=0 with a public car qualified → `entry_denied` pulses once on edge 4, barrier stays 0, `deny_count`=1, `car_entered` never rises.
- **Glitch rejection:** `entry_req` high 2 cycles, low 1, high 2 → no event and no barrier.
- **Collision:** entry and exit both qualify on the same edge with public space available → `car_exited` on edge 4, `car_entered` on edge 5, never coincident.
- **Reset mid-OPEN:** assert `Start` in cycle 3 of OPEN → the barrier drops on that edge, `grant_count` is 0 afterwards, and no event pulse follows.
